pcout_cascade_pipe: RTL and testbench

//   Parametrised PCOUT cascade pipeline for the DSP slice: a DEPTH-stage register bank that

---
 rtl/dsp_slice_pkg.sv | 20 ++
 rtl/pcout_cascade_pipe_if.sv | 43 ++++
 rtl/pcout_stage.sv | 30 +++
 rtl/pcout_cascade_pipe.sv | 108 ++++++++++
 tb/tb_pcout_cascade_pipe.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dsp_slice_pkg.sv
// Shared DSP slice types and sizing helpers for the PCOUT cascade.
// PCOUT_PARITY_EN adds a stored parity bit to each stage tag.
package dsp_slice_pkg;

    localparam int P_WIDTH_DEF     = 48;
    localparam int PCOUT_DEPTH_MAX = 4;

    typedef struct packed {
        logic valid;
        logic carry;
`ifdef PCOUT_PARITY_EN
        logic par;
`endif
    } stage_tag_t;

    function automatic int occ_width(input int depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pcout_cascade_pipe_if.sv
// Cascade bus between the post-adder and the PCOUT/CARRYCASCOUT pins.
// PCOUT_PARITY_EN adds par_out/par_err to the bundle.
interface pcout_cascade_pipe_if
    import dsp_slice_pkg::*;
#(
    parameter int WIDTH = P_WIDTH_DEF,
    parameter int DEPTH = 1
);
    localparam int CW = occ_width(DEPTH);

    logic             cep;
    logic             flushp;
    logic [WIDTH-1:0] p_cout_in;
    logic             carry_in;
    logic             valid_in;
    logic [WIDTH-1:0] p_cout;
    logic             carry_cout;
    logic             valid_out;
    logic [CW-1:0]    occ;
`ifdef PCOUT_PARITY_EN
    logic             par_out;
    logic             par_err;

    modport master (
        output cep, flushp, p_cout_in, carry_in, valid_in,
        input  p_cout, carry_cout, valid_out, occ, par_out, par_err
    );
    modport slave (
        input  cep, flushp, p_cout_in, carry_in, valid_in,
        output p_cout, carry_cout, valid_out, occ, par_out, par_err
    );
`else
    modport master (
        output cep, flushp, p_cout_in, carry_in, valid_in,
        input  p_cout, carry_cout, valid_out, occ
    );
    modport slave (
        input  cep, flushp, p_cout_in, carry_in, valid_in,
        output p_cout, carry_cout, valid_out, occ
    );
`endif

endinterface

// File: rtl/pcout_stage.sv
// One cascade register stage: flush clears only the valid tag,
// enable loads tag and data together.
module pcout_stage
    import dsp_slice_pkg::*;
#(
    parameter int WIDTH = P_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             flush,
    input  stage_tag_t       d_tag,
    input  logic [WIDTH-1:0] d_data,
    output stage_tag_t       q_tag,
    output logic [WIDTH-1:0] q_data
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_tag  <= '0;
            q_data <= '0;
        end else if (flush) begin
            q_tag.valid <= 1'b0;
        end else if (en) begin
            q_tag  <= d_tag;
            q_data <= d_data;
        end
    end

endmodule

// File: rtl/pcout_cascade_pipe.sv
// DEPTH-stage PCOUT cascade pipe with occupancy count.
// PCOUT_PARITY_EN enables per-stage parity and a sticky error flag.
module pcout_cascade_pipe
    import dsp_slice_pkg::*;
#(
    parameter int WIDTH = P_WIDTH_DEF,
    parameter int DEPTH = 1
) (
    input  logic                CLK,
    input  logic                RSTP,
    pcout_cascade_pipe_if.slave pif
);

    localparam int CW = occ_width(DEPTH);

    stage_tag_t in_tag;

    always_comb begin
        in_tag       = '0;
        in_tag.valid = pif.valid_in;
        in_tag.carry = pif.carry_in;
`ifdef PCOUT_PARITY_EN
        in_tag.par   = ^{pif.carry_in, pif.p_cout_in};
`endif
    end

    generate
        if (DEPTH == 0) begin : g_pass
            logic unused;

            assign pif.p_cout     = pif.p_cout_in;
            assign pif.carry_cout = in_tag.carry;
            assign pif.valid_out  = in_tag.valid;
            assign pif.occ        = '0;
`ifdef PCOUT_PARITY_EN
            assign pif.par_out    = in_tag.par;
            assign pif.par_err    = 1'b0;
`endif
            // Control pins are inert without storage.
            assign unused = ^{CLK, RSTP, pif.cep, pif.flushp};
        end else begin : g_pipe
            stage_tag_t       tag_q  [DEPTH];
            logic [WIDTH-1:0] data_q [DEPTH];
            logic [CW-1:0]    occ_q;

            for (genvar k = 0; k < DEPTH; k++) begin : g_stage
                stage_tag_t       d_tag;
                logic [WIDTH-1:0] d_data;

                if (k == 0) begin : g_head
                    assign d_tag  = in_tag;
                    assign d_data = pif.p_cout_in;
                end else begin : g_body
                    assign d_tag  = tag_q[k-1];
                    assign d_data = data_q[k-1];
                end

                pcout_stage #(
                    .WIDTH (WIDTH)
                ) u_stage (
                    .clk    (CLK),
                    .rst    (RSTP),
                    .en     (pif.cep),
                    .flush  (pif.flushp),
                    .d_tag  (d_tag),
                    .d_data (d_data),
                    .q_tag  (tag_q[k]),
                    .q_data (data_q[k])
                );
            end

            assign pif.p_cout     = data_q[DEPTH-1];
            assign pif.carry_cout = tag_q[DEPTH-1].carry;
            assign pif.valid_out  = tag_q[DEPTH-1].valid;
            assign pif.occ        = occ_q;

            // Incremental count tracks popcount of the valid tags.
            always_ff @(posedge CLK or posedge RSTP) begin
                if (RSTP) begin
                    occ_q <= '0;
                end else if (pif.flushp) begin
                    occ_q <= '0;
                end else if (pif.cep) begin
                    occ_q <= occ_q + CW'(pif.valid_in)
                           - CW'(tag_q[DEPTH-1].valid);
                end
            end

`ifdef PCOUT_PARITY_EN
            logic par_err_q;

            assign pif.par_out = tag_q[DEPTH-1].par;
            assign pif.par_err = par_err_q;

            // Checks the delivered word, so upsets on the pins are seen too.
            always_ff @(posedge CLK or posedge RSTP) begin
                if (RSTP) begin
                    par_err_q <= 1'b0;
                end else if (pif.valid_out &&
                             ((^{pif.carry_cout, pif.p_cout}) != pif.par_out)) begin
                    par_err_q <= 1'b1;
                end
            end
`endif
        end
    endgenerate

endmodule

// File: tb/tb_pcout_cascade_pipe.sv
// Scoreboard bench for pcout_cascade_pipe at DEPTH 0, 2, 3 and 4.
// Parity checks run only when PCOUT_PARITY_EN is defined.
module tb_pcout_cascade_pipe;

    typedef struct {
        logic        carry;
        logic [47:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic rst4;

    int n_tests = 0;
    int n_fail  = 0;

    exp_t q2[$];
    exp_t q3[$];
    logic sh2 = 1'b0;
    logic sh3 = 1'b0;

    always #5 clk = ~clk;

    pcout_cascade_pipe_if #(.WIDTH(48), .DEPTH(0)) if0 ();
    pcout_cascade_pipe_if #(.WIDTH(48), .DEPTH(2)) if2 ();
    pcout_cascade_pipe_if #(.WIDTH(48), .DEPTH(3)) if3 ();
    pcout_cascade_pipe_if #(.WIDTH(48), .DEPTH(4)) if4 ();

    pcout_cascade_pipe #(.WIDTH(48), .DEPTH(0)) u0 (.CLK(clk), .RSTP(rst),  .pif(if0));
    pcout_cascade_pipe #(.WIDTH(48), .DEPTH(2)) u2 (.CLK(clk), .RSTP(rst),  .pif(if2));
    pcout_cascade_pipe #(.WIDTH(48), .DEPTH(3)) u3 (.CLK(clk), .RSTP(rst),  .pif(if3));
    pcout_cascade_pipe #(.WIDTH(48), .DEPTH(4)) u4 (.CLK(clk), .RSTP(rst4), .pif(if4));

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Monitors: pop one expectation per shift that presents a valid word.
    always @(posedge clk) begin
        sh2 = if2.cep && !if2.flushp && !rst;
        #1;
        if (sh2 && if2.valid_out) begin
            n_tests++;
            if (q2.size() == 0) begin
                n_fail++;
                $display("FAIL sb2_unexpected: got %h expected none", if2.p_cout);
            end else begin
                exp_t e;
                e = q2.pop_front();
                if (if2.p_cout !== e.data || if2.carry_cout !== e.carry) begin
                    n_fail++;
                    $display("FAIL sb2_word: got %b/%h expected %b/%h",
                             if2.carry_cout, if2.p_cout, e.carry, e.data);
                end
            end
        end
    end

    always @(posedge clk) begin
        sh3 = if3.cep && !if3.flushp && !rst;
        #1;
        if (sh3 && if3.valid_out) begin
            n_tests++;
            if (q3.size() == 0) begin
                n_fail++;
                $display("FAIL sb3_unexpected: got %h expected none", if3.p_cout);
            end else begin
                exp_t e;
                e = q3.pop_front();
                if (if3.p_cout !== e.data || if3.carry_cout !== e.carry) begin
                    n_fail++;
                    $display("FAIL sb3_word: got %b/%h expected %b/%h",
                             if3.carry_cout, if3.p_cout, e.carry, e.data);
                end
            end
        end
    end

    task automatic drive3(input logic v, input logic c, input logic [47:0] d);
        if3.valid_in  = v;
        if3.carry_in  = c;
        if3.p_cout_in = d;
        if (v && if3.cep && !if3.flushp) q3.push_back('{c, d});
    endtask

    task automatic drive2(input logic v, input logic c, input logic [47:0] d);
        if2.valid_in  = v;
        if2.carry_in  = c;
        if2.p_cout_in = d;
        if (v && if2.cep && !if2.flushp) q2.push_back('{c, d});
    endtask

    task automatic drive4(input logic v, input logic c, input logic [47:0] d);
        if4.valid_in  = v;
        if4.carry_in  = c;
        if4.p_cout_in = d;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        logic [47:0] a, b;
        rst = 1'b1;
        rst4 = 1'b1;
        if0.cep = 1'b0; if0.flushp = 1'b0;
        if0.valid_in = 1'b0; if0.carry_in = 1'b0; if0.p_cout_in = '0;
        if2.cep = 1'b0; if2.flushp = 1'b0;
        if3.cep = 1'b0; if3.flushp = 1'b0;
        if4.cep = 1'b0; if4.flushp = 1'b0;
        drive2(1'b0, 1'b0, '0);
        drive3(1'b0, 1'b0, '0);
        drive4(1'b0, 1'b0, '0);
        tick();
        tick();
        rst = 1'b0;
        rst4 = 1'b0;

        check("rst_d3_data", 64'(if3.p_cout), 64'h0);
        check("rst_d3_valid", 64'(if3.valid_out), 64'h0);
        check("rst_d3_occ", 64'(if3.occ), 64'h0);
        check("rst_d2_occ", 64'(if2.occ), 64'h0);

        // Latency through three stages, OCC climbs 1,2,3.
        if3.cep = 1'b1;
        drive3(1'b1, 1'b1, 48'h0000_1234_5678);
        tick();
        check("lat_occ1", 64'(if3.occ), 64'd1);
        check("lat_v1", 64'(if3.valid_out), 64'h0);
        drive3(1'b1, 1'b0, 48'h8000_0000_0001);
        tick();
        check("lat_occ2", 64'(if3.occ), 64'd2);
        check("lat_v2", 64'(if3.valid_out), 64'h0);
        drive3(1'b1, 1'b1, 48'h0FED_CBA9_8765);
        tick();
        check("lat_occ3", 64'(if3.occ), 64'd3);
        check("lat_data", 64'(if3.p_cout), 64'h0000_1234_5678);
        check("lat_carry", 64'(if3.carry_cout), 64'h1);
        check("lat_valid", 64'(if3.valid_out), 64'h1);
        drive3(1'b0, 1'b0, 48'h0);
        tick();
        check("drain_occ2", 64'(if3.occ), 64'd2);
        tick();
        tick();
        check("drain_occ0", 64'(if3.occ), 64'd0);
        check("drain_valid", 64'(if3.valid_out), 64'h0);
        if3.cep = 1'b0;

        // Stall: A and B loaded, five frozen edges, then B emerges.
        a = 48'hAAAA_0000_0001;
        b = 48'h5555_0000_0002;
        if2.cep = 1'b1;
        drive2(1'b1, 1'b0, a);
        tick();
        drive2(1'b1, 1'b1, b);
        tick();
        check("stall_occ", 64'(if2.occ), 64'd2);
        check("stall_a", 64'(if2.p_cout), 64'(a));
        if2.cep = 1'b0;
        drive2(1'b1, 1'b1, 48'hC0C0_C0C0_C0C0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_data", 64'(if2.p_cout), 64'(a));
            check("hold_occ", 64'(if2.occ), 64'd2);
        end
        if2.cep = 1'b1;
        drive2(1'b0, 1'b0, 48'h0);
        tick();
        check("resume_b", 64'(if2.p_cout), 64'(b));
        check("resume_occ1", 64'(if2.occ), 64'd1);
        tick();
        check("resume_occ0", 64'(if2.occ), 64'd0);

        // Flush beats enable: tags cleared, data kept.
        a = 48'h1357_9BDF_0246;
        b = 48'h8642_0FDB_9753;
        drive2(1'b1, 1'b1, a);
        tick();
        drive2(1'b1, 1'b0, b);
        tick();
        check("pre_flush_occ", 64'(if2.occ), 64'd2);
        if2.flushp = 1'b1;
        drive2(1'b1, 1'b0, 48'hFFFF_0000_FFFF);
        q2.delete();
        tick();
        check("flush_occ", 64'(if2.occ), 64'd0);
        check("flush_valid", 64'(if2.valid_out), 64'h0);
        check("flush_data", 64'(if2.p_cout), 64'(a));
        check("flush_carry", 64'(if2.carry_cout), 64'h1);
        if2.flushp = 1'b0;
        drive2(1'b0, 1'b0, 48'h0);
        tick();
        check("inv_shift_data", 64'(if2.p_cout), 64'(b));
        check("inv_shift_valid", 64'(if2.valid_out), 64'h0);
        check("no_underflow", 64'(if2.occ), 64'd0);
        if2.cep = 1'b0;

        // Async reset mid-run on DEPTH=4 with OCC=3.
        if4.cep = 1'b1;
        drive4(1'b0, 1'b1, 48'h0000_0000_1111);
        tick();
        drive4(1'b1, 1'b0, 48'h0000_0000_2222);
        tick();
        drive4(1'b1, 1'b1, 48'h0000_0000_3333);
        tick();
        drive4(1'b1, 1'b0, 48'h0000_0000_4444);
        tick();
        check("d4_occ3", 64'(if4.occ), 64'd3);
        check("d4_tail", 64'(if4.p_cout), 64'h1111);
        rst4 = 1'b1;
        #1;
        check("async_data", 64'(if4.p_cout), 64'h0);
        check("async_valid", 64'(if4.valid_out), 64'h0);
        check("async_occ", 64'(if4.occ), 64'h0);
        tick();
        rst4 = 1'b0;
        drive4(1'b1, 1'b0, 48'h0000_0000_5555);
        tick();
        check("post_rst_occ", 64'(if4.occ), 64'd1);

        // DEPTH=0 passthrough.
        if0.cep = 1'b1;
        if0.flushp = 1'b1;
        if0.valid_in = 1'b1;
        if0.carry_in = 1'b0;
        if0.p_cout_in = 48'h1;
        #1;
        check("d0_data1", 64'(if0.p_cout), 64'h1);
        check("d0_valid1", 64'(if0.valid_out), 64'h1);
        check("d0_occ", 64'(if0.occ), 64'h0);
        if0.cep = 1'b0;
        if0.valid_in = 1'b0;
        if0.carry_in = 1'b1;
        if0.p_cout_in = 48'hFFFF_FFFF_FFFF;
        #1;
        check("d0_data2", 64'(if0.p_cout), 64'hFFFF_FFFF_FFFF);
        check("d0_carry2", 64'(if0.carry_cout), 64'h1);
        check("d0_valid2", 64'(if0.valid_out), 64'h0);

`ifdef PCOUT_PARITY_EN
        begin
            logic [47:0] bad;
            drive4(1'b1, 1'b1, 48'h0000_0000_0007);
            for (int i = 0; i < 4; i++) tick();
            check("par_out", 64'(if4.par_out), 64'h0);
            check("par_err_clean", 64'(if4.par_err), 64'h0);
            bad = 48'h0000_0000_0006;
            force if4.p_cout = bad;
            tick();
            check("par_err_set", 64'(if4.par_err), 64'h1);
            release if4.p_cout;
            if4.flushp = 1'b1;
            tick();
            if4.flushp = 1'b0;
            if4.cep = 1'b0;
            tick();
            check("par_err_sticky", 64'(if4.par_err), 64'h1);
            rst4 = 1'b1;
            #1;
            check("par_err_rst", 64'(if4.par_err), 64'h0);
            tick();
            rst4 = 1'b0;
        end
`endif

        tick();
        check("sb2_empty", 64'(q2.size()), 64'd0);
        check("sb3_empty", 64'(q3.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
